raizing_pll_seq: RTL and testbench



---
 rtl/raizing_pll_pkg.sv | 29 ++
 rtl/raizing_sync2.sv | 24 ++
 rtl/raizing_pll_seq.sv | 133 +++++++++++++
 tb/tb_raizing_pll_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raizing_pll_pkg.sv
// Shared types and helpers for the Raizing PLL bring-up sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: sequencer state encoding (also exported on the debug port) and a
// constant-evaluable ceil(log2) used to size the shared sequencing timer.
package raizing_pll_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_t;

    // Bits needed to count 0 .. value-1; never less than 1.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/raizing_sync2.sv
// Two-flop synchroniser for a single asynchronous level flag.
// Latency: 2 clk cycles from flag change to flag_sync. Backpressure: none.
// Ports: clk (destination clock), rst (sync active-high, clears both flops),
//        flag (async input), flag_sync (synchronised output).
module raizing_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    output logic flag_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b0;
            flag_sync <= 1'b0;
        end else begin
            meta      <= flag;
            flag_sync <= meta;
        end
    end

endmodule

// File: rtl/raizing_pll_seq.sv
// PLL bring-up sequencer: holds the PLL in reset, qualifies lock, retries on
// timeout and releases core_rst only after lock has been stable long enough.
// Latency: all outputs registered; pll_locked edge reaches the FSM after 3 cycles.
// Backpressure: none; relock_req is a one-cycle pulse acted on immediately.
// Ports: refclk, rst (sync active-high); pll_locked (async), relock_req;
//        pll_rst, core_rst, ready, fail; retry_cnt, lost_cnt, state (debug).
module raizing_pll_seq
    import raizing_pll_pkg::*;
#(
    parameter int unsigned RST_HOLD      = 16,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned CORE_RST_HOLD = 64,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    localparam int unsigned MAX_AB    = (RST_HOLD > LOCK_STABLE) ? RST_HOLD : LOCK_STABLE;
    localparam int unsigned MAX_CD    = (LOCK_TIMEOUT > CORE_RST_HOLD) ? LOCK_TIMEOUT : CORE_RST_HOLD;
    localparam int unsigned MAX_PARAM = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          TIMER_W   = clog2(MAX_PARAM);

    // The timer counts 0..N-1 inside a state, so the last cycle is N-1.
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
    localparam logic [TIMER_W-1:0] CRH_LAST     = TIMER_W'(CORE_RST_HOLD - 1);
    localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_state_t         cur_state;
    pll_state_t         nxt_state;
    logic [TIMER_W-1:0] timer;
    logic               lock_s;
    logic               lock_lost;
    logic               retry_inc;
    logic               timer_run;

    raizing_sync2 u_lock_sync (
        .clk       (refclk),
        .rst       (rst),
        .flag      (pll_locked),
        .flag_sync (lock_s)
    );

    assign timer_run = (cur_state != RUN) && (cur_state != FAIL);
    assign state     = cur_state;

    always_comb begin
        nxt_state = cur_state;
        lock_lost = 1'b0;
        retry_inc = 1'b0;
        case (cur_state)
            HOLD: begin
                if (timer == HOLD_LAST) nxt_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins.
                if (lock_s) begin
                    nxt_state = STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_inc = 1'b1;
                    nxt_state = (retry_cnt + 4'd1 == RETRY_LIMIT) ? FAIL : HOLD;
                end
            end
            STABLE: begin
                // A dropout here is not a failed attempt, just restart qualification.
                if (!lock_s)                  nxt_state = WAIT_LOCK;
                else if (timer == STABLE_LAST) nxt_state = RELEASE;
            end
            RELEASE: begin
                if (!lock_s) begin
                    lock_lost = 1'b1;
                    nxt_state = HOLD;
                end else if (timer == CRH_LAST) begin
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lock_lost = 1'b1;
                    nxt_state = HOLD;
                end
            end
            FAIL: begin
                nxt_state = FAIL;
            end
            default: nxt_state = HOLD;
        endcase
        // Re-sequence request overrides everything; lock_lost is still honoured.
        if (relock_req) nxt_state = HOLD;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cur_state <= HOLD;
            timer     <= '0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            lost_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;

            // relock_req in HOLD counts as a fresh entry and restarts the hold.
            if ((nxt_state != cur_state) || relock_req) timer <= '0;
            else if (timer_run)                        timer <= timer + TIMER_W'(1);

            pll_rst  <= (nxt_state == HOLD);
            core_rst <= (nxt_state != RUN);
            ready    <= (nxt_state == RUN);
            fail     <= (nxt_state == FAIL);

            if (relock_req || (nxt_state == RUN)) retry_cnt <= '0;
            else if (retry_inc)                   retry_cnt <= retry_cnt + 4'd1;

            if (lock_lost && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_raizing_pll_seq.sv
// Self-checking bench for raizing_pll_seq: a default-parameter instance for the
// long timing sequences and a small-parameter instance for tables, saturation
// and a randomized run against a behavioural model.
module tb_raizing_pll_seq;

    localparam int ST_HOLD    = 0;
    localparam int ST_WAIT    = 1;
    localparam int ST_STABLE  = 2;
    localparam int ST_RELEASE = 3;
    localparam int ST_RUN     = 4;
    localparam int ST_FAIL    = 5;

    localparam int S_RH  = 4;
    localparam int S_LS  = 8;
    localparam int S_TO  = 50;
    localparam int S_CRH = 4;
    localparam int S_MR  = 3;

    logic refclk = 1'b0;
    always #10 refclk = ~refclk;

    // default instance
    logic       d_rst = 1'b1, d_lock = 1'b0, d_relock = 1'b0;
    logic       d_pll_rst, d_core_rst, d_ready, d_fail;
    logic [3:0] d_retry;
    logic [7:0] d_lost;
    logic [2:0] d_state;

    // small instance
    logic       s_rst = 1'b1, s_lock = 1'b0, s_relock = 1'b0;
    logic       s_pll_rst, s_core_rst, s_ready, s_fail;
    logic [3:0] s_retry;
    logic [7:0] s_lost;
    logic [2:0] s_state;

    raizing_pll_seq u_dflt (
        .refclk(refclk), .rst(d_rst), .pll_locked(d_lock), .relock_req(d_relock),
        .pll_rst(d_pll_rst), .core_rst(d_core_rst), .ready(d_ready), .fail(d_fail),
        .retry_cnt(d_retry), .lost_cnt(d_lost), .state(d_state)
    );

    raizing_pll_seq #(
        .RST_HOLD(S_RH), .LOCK_STABLE(S_LS), .LOCK_TIMEOUT(S_TO),
        .CORE_RST_HOLD(S_CRH), .MAX_RETRY(S_MR)
    ) u_small (
        .refclk(refclk), .rst(s_rst), .pll_locked(s_lock), .relock_req(s_relock),
        .pll_rst(s_pll_rst), .core_rst(s_core_rst), .ready(s_ready), .fail(s_fail),
        .retry_cnt(s_retry), .lost_cnt(s_lost), .state(s_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // ---------------- table-driven vectors (small instance) ----------------
    typedef struct {
        int n;
        bit rst;
        bit lock;
        bit relock;
        int st;
        int retry;
        int lost;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input bit r, input bit lk, input bit rq,
                       input int st, input int rc, input int lc);
        vec_t v;
        v.n = n; v.rst = r; v.lock = lk; v.relock = rq;
        v.st = st; v.retry = rc; v.lost = lc;
        tbl.push_back(v);
    endtask

    // ---------------- behavioural model (small instance) ----------------
    int m_phase, m_elapsed, m_retry, m_lost;
    bit m_q1, m_q2;

    task automatic model_step(input bit r, input bit lk, input bit rq);
        int nph;
        bit seen;
        if (r) begin
            m_phase = ST_HOLD; m_elapsed = 0; m_retry = 0; m_lost = 0;
            m_q1 = 0; m_q2 = 0;
            return;
        end
        seen = m_q2;
        nph  = m_phase;
        case (m_phase)
            ST_HOLD:   if (m_elapsed + 1 >= S_RH) nph = ST_WAIT;
            ST_WAIT: begin
                if (seen) nph = ST_STABLE;
                else if (m_elapsed + 1 >= S_TO) begin
                    m_retry++;
                    nph = (m_retry == S_MR) ? ST_FAIL : ST_HOLD;
                end
            end
            ST_STABLE: begin
                if (!seen) nph = ST_WAIT;
                else if (m_elapsed + 1 >= S_LS) nph = ST_RELEASE;
            end
            ST_RELEASE, ST_RUN: begin
                if (!seen) begin
                    nph = ST_HOLD;
                    if (m_lost < 255) m_lost++;
                end else if (m_phase == ST_RELEASE && m_elapsed + 1 >= S_CRH) begin
                    nph = ST_RUN;
                end
            end
            default: ;
        endcase
        if (rq) begin
            nph = ST_HOLD;
            m_retry = 0;
        end
        if (nph == ST_RUN) m_retry = 0;
        m_elapsed = (nph != m_phase || rq) ? 0 : m_elapsed + 1;
        m_phase = nph;
        m_q2 = m_q1;
        m_q1 = lk;
    endtask

    function automatic int pack(input int st, input int prst, input int crst, input int rdy,
                                input int fl, input int rc, input int lc);
        return st * 65536 + prst * 32768 + crst * 16384 + rdy * 8192 + fl * 4096 + rc * 256 + lc;
    endfunction

    initial begin
        int fall_pll, fall_core, hi, cnt, hold_left;
        bit reached;

        // ===== table on the small instance =====
        add( 2, 1, 0, 0, ST_HOLD,    0, 0);
        add( 3, 0, 0, 0, ST_HOLD,    0, 0);
        add( 1, 0, 0, 0, ST_WAIT,    0, 0);
        add(49, 0, 0, 0, ST_WAIT,    0, 0);
        add( 1, 0, 0, 0, ST_HOLD,    1, 0);
        add( 4, 0, 0, 0, ST_WAIT,    1, 0);
        add(50, 0, 0, 0, ST_HOLD,    2, 0);
        add( 4, 0, 0, 0, ST_WAIT,    2, 0);
        add(49, 0, 0, 0, ST_WAIT,    2, 0);
        add( 1, 0, 0, 0, ST_FAIL,    3, 0);
        add(20, 0, 0, 0, ST_FAIL,    3, 0);
        add( 1, 0, 0, 1, ST_HOLD,    0, 0);
        add( 3, 0, 0, 0, ST_HOLD,    0, 0);
        add( 1, 0, 0, 0, ST_WAIT,    0, 0);
        add( 2, 0, 1, 0, ST_WAIT,    0, 0);
        add( 1, 0, 1, 0, ST_STABLE,  0, 0);
        add( 7, 0, 1, 0, ST_STABLE,  0, 0);
        add( 1, 0, 1, 0, ST_RELEASE, 0, 0);
        add( 3, 0, 1, 0, ST_RELEASE, 0, 0);
        add( 1, 0, 1, 0, ST_RUN,     0, 0);
        add( 5, 0, 1, 0, ST_RUN,     0, 0);
        add( 1, 0, 1, 1, ST_HOLD,    0, 0);
        add( 3, 0, 1, 0, ST_HOLD,    0, 0);
        add( 1, 0, 1, 0, ST_WAIT,    0, 0);
        add( 1, 0, 1, 0, ST_STABLE,  0, 0);
        add( 2, 0, 1, 0, ST_STABLE,  0, 0);
        add( 1, 0, 0, 0, ST_STABLE,  0, 0);
        add( 1, 0, 1, 0, ST_STABLE,  0, 0);
        add( 1, 0, 1, 0, ST_WAIT,    0, 0);
        add( 1, 0, 1, 0, ST_STABLE,  0, 0);
        add( 7, 0, 1, 0, ST_STABLE,  0, 0);
        add( 1, 0, 1, 0, ST_RELEASE, 0, 0);
        add( 2, 0, 0, 0, ST_RELEASE, 0, 0);
        add( 1, 0, 0, 0, ST_HOLD,    0, 1);
        add( 3, 0, 0, 0, ST_HOLD,    0, 1);
        add( 1, 0, 0, 0, ST_WAIT,    0, 1);
        add(47, 0, 0, 0, ST_WAIT,    0, 1);
        add( 2, 0, 1, 0, ST_WAIT,    0, 1);
        add( 1, 0, 1, 0, ST_STABLE,  0, 1);
        add( 8, 0, 1, 0, ST_RELEASE, 0, 1);
        add( 4, 0, 1, 0, ST_RUN,     0, 1);
        add( 2, 0, 0, 0, ST_RUN,     0, 1);
        add( 1, 0, 0, 1, ST_HOLD,    0, 2);
        add( 1, 0, 0, 0, ST_HOLD,    0, 2);
        add( 1, 1, 0, 0, ST_HOLD,    0, 0);

        foreach (tbl[i]) begin
            s_rst = tbl[i].rst; s_lock = tbl[i].lock; s_relock = tbl[i].relock;
            tick(tbl[i].n);
            s_relock = 1'b0;
            check($sformatf("tbl%0d_state", i), int'(s_state), tbl[i].st);
            check($sformatf("tbl%0d_pll_rst", i), int'(s_pll_rst), int'(tbl[i].st == ST_HOLD));
            check($sformatf("tbl%0d_core_rst", i), int'(s_core_rst), int'(tbl[i].st != ST_RUN));
            check($sformatf("tbl%0d_ready", i), int'(s_ready), int'(tbl[i].st == ST_RUN));
            check($sformatf("tbl%0d_fail", i), int'(s_fail), int'(tbl[i].st == ST_FAIL));
            check($sformatf("tbl%0d_retry", i), int'(s_retry), tbl[i].retry);
            check($sformatf("tbl%0d_lost", i), int'(s_lost), tbl[i].lost);
        end

        // ===== default instance: reset values and first bring-up =====
        check("rst_state", int'(d_state), ST_HOLD);
        check("rst_pll_rst", int'(d_pll_rst), 1);
        check("rst_core_rst", int'(d_core_rst), 1);
        check("rst_ready", int'(d_ready), 0);
        check("rst_fail", int'(d_fail), 0);
        check("rst_retry", int'(d_retry), 0);
        check("rst_lost", int'(d_lost), 0);

        d_rst = 1'b0;
        fall_pll = -1; fall_core = -1;
        for (int c = 1; c <= 1300 && fall_core < 0; c++) begin
            tick(1);
            if (fall_pll < 0 && !d_pll_rst) fall_pll = c;
            if (fall_core < 0 && !d_core_rst) fall_core = c;
            if (c == 100) d_lock = 1'b1;
        end
        check("bringup_pll_rst_fall", fall_pll, 16);
        check("bringup_core_rst_fall", fall_core, 100 + 3 + 1024 + 64);
        check("bringup_ready", int'(d_ready), 1);
        check("bringup_retry", int'(d_retry), 0);

        // ===== lock loss in RUN =====
        tick(5);
        d_lock = 1'b0;
        tick(2);
        check("loss_core_rst_2cyc", int'(d_core_rst), 0);
        tick(1);
        check("loss_core_rst_3cyc", int'(d_core_rst), 1);
        check("loss_ready", int'(d_ready), 0);
        check("loss_state", int'(d_state), ST_HOLD);
        check("loss_lost", int'(d_lost), 1);
        hi = d_pll_rst ? 1 : 0;
        for (int c = 0; c < 40 && d_pll_rst; c++) begin
            tick(1);
            if (d_pll_rst) hi++;
        end
        check("loss_pll_rst_width", hi, 16);
        d_lock = 1'b1;
        cnt = -1;
        for (int c = 1; c <= 1200 && cnt < 0; c++) begin
            tick(1);
            if (d_ready) cnt = c;
        end
        check("reseq_to_run", cnt, 3 + 1024 + 64);

        // ===== relock_req in RUN, then rst in RELEASE =====
        d_relock = 1'b1;
        tick(1);
        d_relock = 1'b0;
        check("relock_run_state", int'(d_state), ST_HOLD);
        check("relock_run_retry", int'(d_retry), 0);
        check("relock_run_lost", int'(d_lost), 1);
        check("relock_run_core_rst", int'(d_core_rst), 1);
        reached = 1'b0;
        for (int c = 0; c < 1200 && !reached; c++) begin
            tick(1);
            if (d_state == 3'(ST_RELEASE)) reached = 1'b1;
        end
        check("reach_release", int'(reached), 1);
        tick(5);
        d_rst = 1'b1;
        tick(1);
        check("mid_rst_state", int'(d_state), ST_HOLD);
        check("mid_rst_pll_rst", int'(d_pll_rst), 1);
        check("mid_rst_core_rst", int'(d_core_rst), 1);
        check("mid_rst_ready", int'(d_ready), 0);
        check("mid_rst_fail", int'(d_fail), 0);
        check("mid_rst_retry", int'(d_retry), 0);
        check("mid_rst_lost", int'(d_lost), 0);
        d_rst = 1'b0;
        fall_pll = -1;
        for (int c = 1; c <= 40 && fall_pll < 0; c++) begin
            tick(1);
            if (!d_pll_rst) fall_pll = c;
        end
        check("post_rst_hold_len", fall_pll, 16);

        // ===== lost_cnt saturation (small instance) =====
        s_rst = 1'b1; s_lock = 1'b1; s_relock = 1'b0;
        tick(2);
        s_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            reached = 1'b0;
            for (int c = 0; c < 100 && !reached; c++) begin
                if (s_ready) reached = 1'b1;
                else tick(1);
            end
            if (!reached) begin
                check("sat_reach_run", 0, 1);
                break;
            end
            s_lock = 1'b0;
            tick(3);
            s_lock = 1'b1;
            if (i == 199) check("sat_lost_200", int'(s_lost), 200);
        end
        check("sat_lost_255", int'(s_lost), 255);

        // ===== randomized run against the model (small instance) =====
        s_rst = 1'b1; s_lock = 1'b0; s_relock = 1'b0;
        model_step(1'b1, 1'b0, 1'b0);
        tick(1);
        s_rst = 1'b0;
        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left == 0) begin
                s_lock = ~s_lock;
                hold_left = $urandom_range(1, 70);
            end
            hold_left--;
            s_relock = ($urandom_range(0, 59) == 0);
            s_rst    = ($urandom_range(0, 799) == 0);
            model_step(s_rst, s_lock, s_relock);
            tick(1);
            check($sformatf("rand_cyc%0d", c),
                  pack(int'(s_state), int'(s_pll_rst), int'(s_core_rst), int'(s_ready),
                       int'(s_fail), int'(s_retry), int'(s_lost)),
                  pack(m_phase, int'(m_phase == ST_HOLD), int'(m_phase != ST_RUN),
                       int'(m_phase == ST_RUN), int'(m_phase == ST_FAIL), m_retry, m_lost));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
